input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer.sv | 158 +++++++++++++++
 tb/tb_input_debouncer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Purpose : debounce a raw (possibly asynchronous, bouncing) level; accept a new
//           level only after STABLE_CYCLES consecutive disagreeing samples, and
//           emit one-cycle rise/fall strobes on each accepted change.
// Latency : level/rise/fall change on the STABLE_CYCLES-th sampling edge of a
//           disagreement run (+2 edges when INPUT_DEBOUNCER_SYNC_EN is defined).
// Backpressure: none; the block samples every edge and has no flow control.
//
// Ports:
//   clk   - single clock, all state updates on rising edge
//   rst   - synchronous active-high reset
//   a     - raw level to be filtered
//   level - debounced level (registered)
//   rise  - registered one-cycle strobe on accepted 0->1
//   fall  - registered one-cycle strobe on accepted 1->0
//
// Configuration macro: INPUT_DEBOUNCER_SYNC_EN
//   defined   -> a passes through a 2-flop synchronizer before sampling
//   undefined -> a is sampled directly, no synchronizer flops
module input_debouncer #(
    parameter int STABLE_CYCLES = 4   // legal range 2..255
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic level,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        PEND_HIGH = 2'd1,
        HIGH      = 2'd2,
        PEND_LOW  = 2'd3
    } state_t;

    // Last count value of a pending run; reaching it with one more agreeing
    // sample accepts the new level.
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic       s;

    // ------------------------------------------------------------------
    // Sampling path
    // ------------------------------------------------------------------
`ifdef INPUT_DEBOUNCER_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= a;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = a;
`endif

    // ------------------------------------------------------------------
    // State, counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOW;
            cnt_q   <= 8'd0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        unique case (state_q)
            LOW: begin
                if (s) begin
                    state_d = PEND_HIGH;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d   = 8'd0;
                end
            end

            PEND_HIGH: begin
                if (!s) begin
                    // Run too short: treat as glitch, nothing visible changes.
                    state_d = LOW;
                    cnt_d   = 8'd0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = 8'd0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end

            HIGH: begin
                if (!s) begin
                    state_d = PEND_LOW;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d   = 8'd0;
                end
            end

            PEND_LOW: begin
                if (s) begin
                    state_d = HIGH;
                    cnt_d   = 8'd0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = LOW;
                    cnt_d   = 8'd0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = LOW;
                cnt_d   = 8'd0;
            end
        endcase

        // Level follows the accepted side of the FSM; pending states keep the
        // previously accepted level.
        level_d = (state_d == HIGH) || (state_d == PEND_LOW);
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int SC = 4;

    logic clk;
    logic rst;
    logic a;
    logic level;
    logic rise;
    logic fall;

    int errs;
    int checks;

    input_debouncer #(.STABLE_CYCLES(SC)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive a, let one rising edge pass, then settle away from the edge.
    task automatic step(input logic val);
        a = val;
        @(posedge clk);
        #1;
    endtask

    logic seq_bounce [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    int n_rise, n_fall, n_high, n_fire;
    logic lv_p1, lv_p2;
    logic v;

    initial begin
        errs   = 0;
        checks = 0;
        rst    = 1'b1;
        a      = 1'b0;

        // Reset state
        step(1'b0);
        step(1'b0);
        chk("reset_level", int'(level), 0);
        chk("reset_rise",  int'(rise),  0);
        chk("reset_fall",  int'(fall),  0);
        chk("reset_cnt",   int'(dut.cnt_q), 0);

        // Clean step: 3 lows then held high
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int i = 1; i <= SC + LAT + 1; i++) begin
            step(1'b1);
            chk($sformatf("step_level_%0d", i), int'(level), int'(i >= SC + LAT));
            chk($sformatf("step_rise_%0d", i),  int'(rise),  int'(i == SC + LAT));
            chk($sformatf("step_fall_%0d", i),  int'(fall),  0);
        end

        // Bounce then settle from HIGH: single fall on 4th consecutive 0
        n_fall = 0;
        for (int i = 0; i < 9 + LAT + 1; i++) begin
            v = (i < 9) ? seq_bounce[i] : 1'b0;
            step(v);
            if (fall) n_fall++;
            chk($sformatf("bounce_fall_%0d", i),  int'(fall),  int'(i == 8 + LAT));
            chk($sformatf("bounce_level_%0d", i), int'(level), int'(i < 8 + LAT));
        end
        chk("bounce_fall_count", n_fall, 1);

        // Glitch rejection from LOW: 1,1,1,0 then 0 held
        n_rise = 0;
        for (int i = 0; i < 4 + LAT + 2; i++) begin
            step((i < 3) ? 1'b1 : 1'b0);
            if (rise) n_rise++;
            chk($sformatf("glitch_level_%0d", i), int'(level), 0);
        end
        chk("glitch_rise_count", n_rise, 0);
        chk("glitch_cnt", int'(dut.cnt_q), 0);

        // Reset while pending high with cnt=2
        for (int i = 0; i < 2 + LAT; i++) step(1'b1);
        chk("pend_cnt", int'(dut.cnt_q), 2);
        rst = 1'b1;
        step(1'b1);
        chk("pend_rst_level", int'(level), 0);
        chk("pend_rst_rise",  int'(rise),  0);
        chk("pend_rst_cnt",   int'(dut.cnt_q), 0);
        rst = 1'b0;
        for (int i = 1; i <= SC + LAT + 1; i++) begin
            step(1'b1);
            chk($sformatf("pend_rise_%0d", i), int'(rise), int'(i == SC + LAT));
        end
        chk("pend_level_high", int'(level), 1);

        // Reset while HIGH: level drops with no fall strobe
        rst = 1'b1;
        step(1'b1);
        chk("high_rst_level", int'(level), 0);
        chk("high_rst_fall",  int'(fall),  0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0);
        chk("idle_level", int'(level), 0);

        // Downstream chain: 5-cycle burst, single-cycle pulse detector on level
        n_rise = 0;
        n_fall = 0;
        n_high = 0;
        n_fire = 0;
        lv_p1  = level;
        lv_p2  = level;
        for (int i = 0; i < 15; i++) begin
            step((i < 5) ? 1'b1 : 1'b0);
            if (rise)  n_rise++;
            if (fall)  n_fall++;
            if (level) n_high++;
            if (!lv_p2 && lv_p1 && !level) n_fire++;
            lv_p2 = lv_p1;
            lv_p1 = level;
        end
        chk("burst_high_cycles", n_high, 5);
        chk("burst_pulse_fires", n_fire, 0);
        chk("burst_rises", n_rise, 1);
        chk("burst_falls", n_fall, 1);
        chk("burst_end_level", int'(level), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
